// File: rtl/fruit_bbox_detect_if.sv
// fruit_bbox_detect_if
// Bundles the windowed video input, the delayed video output and the latched
// per-frame detection results of fruit_bbox_detect.
//   master : video source / result consumer (drives i_*, reads everything else)
//   slave  : the detector (reads i_*, drives o_*, box_*, pix_cnt, box_valid, frame_done)
interface fruit_bbox_detect_if;
  logic [23:0] i_rgb;
  logic        i_hsync;
  logic        i_vsync;
  logic        i_de;
  logic [23:0] o_rgb;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [11:0] box_x_l;
  logic [11:0] box_x_r;
  logic [11:0] box_y_t;
  logic [11:0] box_y_b;
  logic [19:0] pix_cnt;
  logic        box_valid;
  logic        frame_done;

  modport master (
    output i_rgb, i_hsync, i_vsync, i_de,
    input  o_rgb, o_hsync, o_vsync, o_de,
    input  box_x_l, box_x_r, box_y_t, box_y_b, pix_cnt, box_valid, frame_done
  );

  modport slave (
    input  i_rgb, i_hsync, i_vsync, i_de,
    output o_rgb, o_hsync, o_vsync, o_de,
    output box_x_l, box_x_r, box_y_t, box_y_b, pix_cnt, box_valid, frame_done
  );
endinterface

// File: rtl/fruit_bbox_detect.sv
// fruit_bbox_detect
// Classifies active pixels against a fixed RGB colour box, accumulates a
// per-frame bounding box and hit count, latches them at each frame start and
// passes the video through with a fixed 2-cycle latency.
// Ports:
//   pixelclk : pixel clock, rising edge
//   reset    : synchronous active-high reset
//   vif      : fruit_bbox_detect_if.slave (video in/out, latched results)
// Build option:
//   FRUIT_BBOX_OVERLAY_EN : when defined, the latched box border is drawn in
//                           BOX_COLOR on the output video (latency unchanged).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | after reset, waiting for the first frame start; pixels ignored
// S_ACCUM | accumulating matches of the current frame
// S_LATCH | one cycle after frame start: results visible, frame_done=1,
//         | accumulators cleared (a de=1 pixel in this cycle is dropped)
module fruit_bbox_detect #(
  parameter int          R_MIN      = 150,
  parameter int          R_MAX      = 255,
  parameter int          G_MIN      = 0,
  parameter int          G_MAX      = 100,
  parameter int          B_MIN      = 0,
  parameter int          B_MAX      = 100,
  parameter int          MIN_PIXELS = 64,
  parameter bit          VS_POL     = 1'b1,
  parameter logic [23:0] BOX_COLOR  = 24'h00FF00
) (
  input logic                pixelclk,
  input logic                reset,
  fruit_bbox_detect_if.slave vif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LATCH} state_e;

  function automatic logic in_range(logic [7:0] v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

  state_e      state_q, state_d;
  logic        vs_prev_q, vs_prev_d;
  logic        de_prev_q, de_prev_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [11:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [11:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [19:0] cnt_q, cnt_d;
  logic [11:0] box_x_l_q, box_x_l_d, box_x_r_q, box_x_r_d;
  logic [11:0] box_y_t_q, box_y_t_d, box_y_b_q, box_y_b_d;
  logic [19:0] pix_cnt_q, pix_cnt_d;
  logic        box_valid_q, box_valid_d;
  logic [23:0] rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d;
  logic        hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic        de_s1_q, de_s1_d, de_s2_q, de_s2_d;

  logic fs, de_fall, match;
  logic acc_clr, acc_en, res_load;

  always_comb begin
    vs_prev_d = (vif.i_vsync == VS_POL);
    de_prev_d = vif.i_de;
    fs        = (vif.i_vsync == VS_POL) & ~vs_prev_q;
    de_fall   = de_prev_q & ~vif.i_de;
    match     = vif.i_de
              & in_range(vif.i_rgb[23:16], R_MIN, R_MAX)
              & in_range(vif.i_rgb[15:8],  G_MIN, G_MAX)
              & in_range(vif.i_rgb[7:0],   B_MIN, B_MAX);

    x_d = vif.i_de ? x_q + 12'd1 : 12'd0;
    if (fs)           y_d = 12'd0;
    else if (de_fall) y_d = y_q + 12'd1;
    else              y_d = y_q;

    state_d  = state_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    res_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fs) begin
          state_d = S_ACCUM;
          acc_clr = 1'b1;
        end
      end
      S_ACCUM: begin
        // The pixel on the fs cycle still belongs to the frame being closed.
        acc_en = match;
        if (fs) begin
          state_d  = S_LATCH;
          res_load = 1'b1;
        end
      end
      S_LATCH: begin
        state_d = S_ACCUM;
        acc_clr = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (acc_clr) begin
      xmin_d = 12'hFFF;
      xmax_d = 12'h000;
      ymin_d = 12'hFFF;
      ymax_d = 12'h000;
      cnt_d  = 20'd0;
    end else if (acc_en) begin
      if (x_q < xmin_q) xmin_d = x_q;
      if (x_q > xmax_q) xmax_d = x_q;
      if (y_q < ymin_q) ymin_d = y_q;
      if (y_q > ymax_q) ymax_d = y_q;
      if (cnt_q != 20'hFFFFF) cnt_d = cnt_q + 20'd1;
    end

    // Results are loaded from the updated accumulators on the fs edge so that
    // they are already stable during the LATCH cycle that carries frame_done.
    box_x_l_d   = res_load ? xmin_d : box_x_l_q;
    box_x_r_d   = res_load ? xmax_d : box_x_r_q;
    box_y_t_d   = res_load ? ymin_d : box_y_t_q;
    box_y_b_d   = res_load ? ymax_d : box_y_b_q;
    pix_cnt_d   = res_load ? cnt_d  : pix_cnt_q;
    box_valid_d = res_load ? (cnt_d >= 20'(MIN_PIXELS)) : box_valid_q;

    rgb_s1_d = vif.i_rgb;
    hs_s1_d  = vif.i_hsync;
    vs_s1_d  = vif.i_vsync;
    de_s1_d  = vif.i_de;
    hs_s2_d  = hs_s1_q;
    vs_s2_d  = vs_s1_q;
    de_s2_d  = de_s1_q;
  end

`ifdef FRUIT_BBOX_OVERLAY_EN
  logic [11:0] x_s1_q, x_s1_d, y_s1_q, y_s1_d;
  logic        on_border;

  always_comb begin
    x_s1_d    = x_q;
    y_s1_d    = y_q;
    on_border = (((x_s1_q == box_x_l_q) || (x_s1_q == box_x_r_q)) &&
                 (y_s1_q >= box_y_t_q) && (y_s1_q <= box_y_b_q)) ||
                (((y_s1_q == box_y_t_q) || (y_s1_q == box_y_b_q)) &&
                 (x_s1_q >= box_x_l_q) && (x_s1_q <= box_x_r_q));
    rgb_s2_d  = (box_valid_q && de_s1_q && on_border) ? BOX_COLOR : rgb_s1_q;
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      x_s1_q <= '0;
      y_s1_q <= '0;
    end else begin
      x_s1_q <= x_s1_d;
      y_s1_q <= y_s1_d;
    end
  end
`else
  logic [23:0] unused_box_color;
  assign unused_box_color = BOX_COLOR;

  always_comb begin
    rgb_s2_d = rgb_s1_q;
  end
`endif

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vs_prev_q   <= 1'b0;
      de_prev_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      xmin_q      <= 12'hFFF;
      xmax_q      <= '0;
      ymin_q      <= 12'hFFF;
      ymax_q      <= '0;
      cnt_q       <= '0;
      box_x_l_q   <= '0;
      box_x_r_q   <= '0;
      box_y_t_q   <= '0;
      box_y_b_q   <= '0;
      pix_cnt_q   <= '0;
      box_valid_q <= 1'b0;
      rgb_s1_q    <= '0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      de_s1_q     <= 1'b0;
      rgb_s2_q    <= '0;
      hs_s2_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      de_s2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_prev_q   <= vs_prev_d;
      de_prev_q   <= de_prev_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      cnt_q       <= cnt_d;
      box_x_l_q   <= box_x_l_d;
      box_x_r_q   <= box_x_r_d;
      box_y_t_q   <= box_y_t_d;
      box_y_b_q   <= box_y_b_d;
      pix_cnt_q   <= pix_cnt_d;
      box_valid_q <= box_valid_d;
      rgb_s1_q    <= rgb_s1_d;
      hs_s1_q     <= hs_s1_d;
      vs_s1_q     <= vs_s1_d;
      de_s1_q     <= de_s1_d;
      rgb_s2_q    <= rgb_s2_d;
      hs_s2_q     <= hs_s2_d;
      vs_s2_q     <= vs_s2_d;
      de_s2_q     <= de_s2_d;
    end
  end

  assign vif.o_rgb      = rgb_s2_q;
  assign vif.o_hsync    = hs_s2_q;
  assign vif.o_vsync    = vs_s2_q;
  assign vif.o_de       = de_s2_q;
  assign vif.box_x_l    = box_x_l_q;
  assign vif.box_x_r    = box_x_r_q;
  assign vif.box_y_t    = box_y_t_q;
  assign vif.box_y_b    = box_y_b_q;
  assign vif.pix_cnt    = pix_cnt_q;
  assign vif.box_valid  = box_valid_q;
  assign vif.frame_done = (state_q == S_LATCH);

endmodule

// File: tb/tb_fruit_bbox_detect.sv
// tb_fruit_bbox_detect
// Directed frame table plus randomized video against a frame-level reference
// model (hit list per frame, video history) for fruit_bbox_detect.
// Honours FRUIT_BBOX_OVERLAY_EN the same way as the design.
module tb_fruit_bbox_detect;
  logic pixelclk = 1'b0;
  logic reset;

  fruit_bbox_detect_if vif ();
  fruit_bbox_detect dut (.pixelclk(pixelclk), .reset(reset), .vif(vif));

  always #5 pixelclk = ~pixelclk;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_count = 0;

  typedef struct {
    int x;
    int y;
  } pt_t;

  typedef struct {
    int          w, h, x0, x1, y0, y1;
    logic [23:0] fg, bg;
    int          xl, xr, yt, yb, cnt;
    bit          valid;
  } vec_t;

  // reference model state
  pt_t         m_hits[$];
  bit          m_armed, m_drop, m_vs_prev, m_de_prev;
  int          m_x, m_y;
  int          e_xl, e_xr, e_yt, e_yb, e_cnt;
  bit          e_valid, e_fd;
  logic [23:0] p_rgb;
  logic        p_hs, p_vs, p_de;
  int          p_x, p_y;
  logic [26:0] e_video;
  bit          probe = 1'b0;
  int          n_probe = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit color_hit(logic [23:0] c);
    int r, g, b;
    r = int'(c[23:16]);
    g = int'(c[15:8]);
    b = int'(c[7:0]);
    return (r >= 150) && (r <= 255) && (g >= 0) && (g <= 100) && (b >= 0) && (b <= 100);
  endfunction

  function automatic bit on_border(int x, int y);
    return ((x == e_xl || x == e_xr) && y >= e_yt && y <= e_yb) ||
           ((y == e_yt || y == e_yb) && x >= e_xl && x <= e_xr);
  endfunction

  task automatic summarize();
    e_xl = 4095; e_xr = 0; e_yt = 4095; e_yb = 0;
    foreach (m_hits[i]) begin
      if (m_hits[i].x < e_xl) e_xl = m_hits[i].x;
      if (m_hits[i].x > e_xr) e_xr = m_hits[i].x;
      if (m_hits[i].y < e_yt) e_yt = m_hits[i].y;
      if (m_hits[i].y > e_yb) e_yb = m_hits[i].y;
    end
    e_cnt   = (m_hits.size() > 1048575) ? 1048575 : m_hits.size();
    e_valid = (e_cnt >= 64);
  endtask

  task automatic drive(logic [23:0] rgb, logic hs, logic vs, logic de);
    vif.i_rgb   = rgb;
    vif.i_hsync = hs;
    vif.i_vsync = vs;
    vif.i_de    = de;
  endtask

  // Advance the model by one pixel, clock the DUT, then compare everything.
  task automatic tick();
    bit          fs;
    logic [23:0] orgb;
    int          ox, oy;
    bit          ode;
    ox = 0; oy = 0; ode = 1'b0;
    if (reset) begin
      m_hits.delete();
      m_armed = 0; m_drop = 0; m_vs_prev = 0; m_de_prev = 0;
      m_x = 0; m_y = 0;
      e_xl = 0; e_xr = 0; e_yt = 0; e_yb = 0; e_cnt = 0; e_valid = 0; e_fd = 0;
      p_rgb = '0; p_hs = 0; p_vs = 0; p_de = 0; p_x = 0; p_y = 0;
      e_video = '0;
      fd_count = 0;
    end else begin
      fs   = (vif.i_vsync == 1'b1) && !m_vs_prev;
      orgb = p_rgb;
`ifdef FRUIT_BBOX_OVERLAY_EN
      if (e_valid && p_de && on_border(p_x, p_y)) orgb = 24'h00FF00;
`endif
      e_video = {orgb, p_hs, p_vs, p_de};
      ox = p_x; oy = p_y; ode = p_de;
      p_rgb = vif.i_rgb; p_hs = vif.i_hsync; p_vs = vif.i_vsync; p_de = vif.i_de;
      p_x = m_x; p_y = m_y;
      e_fd = 0;
      if (m_drop) m_drop = 0;
      else if (m_armed && vif.i_de && color_hit(vif.i_rgb)) m_hits.push_back('{m_x, m_y});
      if (fs) begin
        if (m_armed) begin
          summarize();
          e_fd   = 1;
          m_drop = 1;
        end
        m_armed = 1;
        m_hits.delete();
      end
      if (fs)                          m_y = 0;
      else if (m_de_prev && !vif.i_de) m_y = (m_y + 1) % 4096;
      m_x       = vif.i_de ? (m_x + 1) % 4096 : 0;
      m_vs_prev = (vif.i_vsync == 1'b1);
      m_de_prev = vif.i_de;
    end
    @(posedge pixelclk);
    #1;
    if (vif.frame_done) fd_count++;
    check("video", 64'({vif.o_rgb, vif.o_hsync, vif.o_vsync, vif.o_de}), 64'(e_video));
    check("box", {16'h0, vif.box_x_l, vif.box_x_r, vif.box_y_t, vif.box_y_b},
          {16'h0, 12'(e_xl), 12'(e_xr), 12'(e_yt), 12'(e_yb)});
    check("cnt_valid_fd", 64'({vif.pix_cnt, vif.box_valid, vif.frame_done}),
          64'({20'(e_cnt), e_valid, e_fd}));
    if (probe && ode) begin
      if (ox == 20 && oy == 10) begin n_probe++; check("ovl_20_10", 64'(vif.o_rgb), 64'h00FF00); end
      if (ox == 25 && oy == 5)  begin n_probe++; check("ovl_25_5",  64'(vif.o_rgb), 64'h00FF00); end
      if (ox == 25 && oy == 10) begin n_probe++; check("ovl_25_10", 64'(vif.o_rgb), 64'h123456); end
    end
  endtask

  task automatic send_frame(int w, int h, int x0, int x1, int y0, int y1,
                            logic [23:0] fg, logic [23:0] bg, int abort_line);
    for (int k = 0; k < 3; k++) begin drive(24'h0, 1'b0, 1'b1, 1'b0); tick(); end
    for (int k = 0; k < 2; k++) begin drive(24'h0, 1'b0, 1'b0, 1'b0); tick(); end
    for (int l = 0; l < h; l++) begin
      if (l == abort_line) return;
      for (int c = 0; c < w; c++) begin
        drive((c >= x0 && c <= x1 && l >= y0 && l <= y1) ? fg : bg, 1'b0, 1'b0, 1'b1);
        tick();
      end
      for (int k = 0; k < 4; k++) begin drive(24'h0, (k < 2), 1'b0, 1'b0); tick(); end
    end
  endtask

  task automatic close_frame();
    drive(24'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check("fd_after_fs", 64'(vif.frame_done), 64'd1);
    tick();
    check("fd_one_cycle", 64'(vif.frame_done), 64'd0);
    tick();
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic check_results(string tag, int xl, int xr, int yt, int yb, int cnt, bit valid);
    check({tag, "_x_l"},   64'(vif.box_x_l),   64'(xl));
    check({tag, "_x_r"},   64'(vif.box_x_r),   64'(xr));
    check({tag, "_y_t"},   64'(vif.box_y_t),   64'(yt));
    check({tag, "_y_b"},   64'(vif.box_y_b),   64'(yb));
    check({tag, "_cnt"},   64'(vif.pix_cnt),   64'(cnt));
    check({tag, "_valid"}, 64'(vif.box_valid), 64'(valid));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic de_r, vs_r;
    logic [23:0] rgb_r;

    tbl[0] = '{8,  4,  0,  7,  0, 3,  24'hFF0000, 24'h000000, 0,    7,  0,    3,  32,  1'b0};
    tbl[1] = '{64, 64, 20, 29, 5, 14, 24'hFF0000, 24'h000000, 20,   29, 5,    14, 100, 1'b1};
    tbl[2] = '{16, 8,  0,  15, 0, 7,  24'h00FF00, 24'h00FF00, 4095, 0,  4095, 0,  0,   1'b0};
    tbl[3] = '{8,  8,  0,  7,  0, 7,  24'hFF0000, 24'h000000, 0,    7,  0,    7,  64,  1'b1};
    tbl[4] = '{9,  7,  0,  8,  0, 6,  24'hFF6464, 24'h000000, 0,    8,  0,    6,  63,  1'b0};
    tbl[5] = '{16, 16, 3,  12, 2, 8,  24'h966464, 24'h956565, 3,    12, 2,    8,  70,  1'b1};

    reset = 1'b1;
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    tick();
    check_results("reset", 0, 0, 0, 0, 0, 1'b0);
    check("reset_fd", 64'(vif.frame_done), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].w, tbl[i].h, tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1,
                 tbl[i].fg, tbl[i].bg, -1);
      if (i == 0) check("no_fd_first_frame", 64'(fd_count), 64'd0);
      close_frame();
      check_results($sformatf("vec%0d", i), tbl[i].xl, tbl[i].xr, tbl[i].yt, tbl[i].yb,
                    tbl[i].cnt, tbl[i].valid);
    end

    // reset in the middle of an accumulating frame
    send_frame(64, 64, 20, 29, 5, 14, 24'hFF0000, 24'h000000, 10);
    reset = 1'b1;
    tick();
    check_results("midrst", 0, 0, 0, 0, 0, 1'b0);
    check("midrst_video", 64'({vif.o_rgb, vif.o_hsync, vif.o_vsync, vif.o_de}), 64'd0);
    reset = 1'b0;
    send_frame(64, 64, 20, 29, 5, 14, 24'hFF0000, 24'h000000, -1);
    check("midrst_no_fd", 64'(fd_count), 64'd0);
    close_frame();
    check_results("midrst_next", 20, 29, 5, 14, 100, 1'b1);

`ifdef FRUIT_BBOX_OVERLAY_EN
    send_frame(64, 64, 20, 29, 5, 14, 24'hFF0000, 24'h000000, -1);
    probe   = 1'b1;
    n_probe = 0;
    send_frame(64, 64, 0, 63, 0, 63, 24'h123456, 24'h123456, -1);
    probe   = 1'b0;
    check("ovl_probe_count", 64'(n_probe), 64'd3);
`endif

    // randomized video, half of the pixels near the colour box
    de_r = 1'b0;
    vs_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0)   de_r = ~de_r;
      if ($urandom_range(0, 299) == 0) vs_r = ~vs_r;
      if ($urandom_range(0, 1) == 1)
        rgb_r = {8'($urandom_range(140, 255)), 8'($urandom_range(0, 110)), 8'($urandom_range(0, 110))};
      else
        rgb_r = 24'($urandom);
      drive(rgb_r, 1'($urandom_range(0, 1)), vs_r, de_r);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fruit_bbox_detect.md
Name: fruit_bbox_detect

Overview:
- Sits directly downstream of the ISP capture-window stage and consumes its windowed video (RGB, hsync, vsync, de); pixels outside the window arrive as black.
- Classifies each active pixel against a fixed RGB colour box and accumulates a per-frame bounding box and hit count of matching pixels.
- At each frame boundary, latches the result for the recognition/UI logic.
- Passes the video through with fixed latency, optionally drawing the latched box on it.

Parameters:
- R_MIN, 150, lower red bound (inclusive)
- R_MAX, 255, upper red bound (inclusive)
- G_MIN, 0, lower green bound
- G_MAX, 100, upper green bound
- B_MIN, 0, lower blue bound
- B_MAX, 100, upper blue bound
- MIN_PIXELS, 64, minimum hit count for a valid box
- VS_POL, 1, active level of i_vsync
- BOX_COLOR, 24'h00FF00, overlay colour (only used with the optional feature)

Ports:
- pixelclk  in  1  pixel clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- i_rgb  in  24  {R[23:16],G[15:8],B[7:0]}
- i_hsync  in  1  horizontal sync
- i_vsync  in  1  vertical sync, active level VS_POL
- i_de  in  1  active-video enable
- o_rgb  out  24  delayed video
- o_hsync  out  1  delayed hsync
- o_vsync  out  1  delayed vsync
- o_de  out  1  delayed de
- box_x_l  out  12  latched left column
- box_x_r  out  12  latched right column
- box_y_t  out  12  latched top line
- box_y_b  out  12  latched bottom line
- pix_cnt  out  20  latched hit count, saturating
- box_valid  out  1  latched box meets MIN_PIXELS
- frame_done  out  1  one-cycle pulse when results update

Behaviour:
- Reset (one clock, reset=1): all outputs 0; state IDLE; counters 0; accumulators at init values (min=12'hFFF, max=0, cnt=0).
- Video path: 2-stage pipeline. o_rgb/o_hsync/o_vsync/o_de equal the inputs from 2 cycles earlier; all are 0 during reset.
- Frame-start edge (fs): vs_act = (i_vsync==VS_POL). Register vs_act as vs_d. fs=1 on the cycle where vs_act=1 and vs_d=0.
- Coordinates:
  - x counts active pixels in the line: 0 for the first de=1 pixel, +1 per de=1 cycle, cleared when de falls.
  - y increments on each de falling edge and is cleared on fs.
  - Both counters are 12-bit and wrap silently.
- Match: i_de=1 and R_MIN<=R<=R_MAX and G_MIN<=G<=G_MAX and B_MIN<=B<=B_MAX, evaluated on the raw input the same cycle. Black masked pixels fail whenever R_MIN>0.
- Accumulate on match:
  - x_min=min(x_min,x); x_max=max(x_max,x); y_min=min(y_min,y); y_max=max(y_max,y).
  - cnt+1, saturating at 20'hFFFFF.
- State machine:
  - IDLE: ignore pixels; on fs go to ACCUM and clear accumulators. The partial frame after reset is never reported.
  - ACCUM: accumulate; on fs go to LATCH.
  - LATCH (1 cycle): copy accumulators to outputs; box_valid=(cnt>=MIN_PIXELS); frame_done=1; clear accumulators; go to ACCUM.
- Latch timing: frame_done asserts exactly 1 cycle after the fs cycle. Outputs hold until the next LATCH.
- Accumulator reset timing: accumulators are cleared on the LATCH cycle, so any pixel with de=1 on that cycle is dropped.
- No-hit frame: cnt=0, box_valid=0, box coordinates latch the init values (x_l=y_t=12'hFFF, x_r=y_b=0). Consumers must gate on box_valid.
- Pixel on fs cycle: if i_de=1 on the fs cycle, that pixel still goes to the frame being closed (counts against old y).
- Reset mid-frame: returns to IDLE; the previously latched results are lost (outputs 0).

Optional Feature:
- Macro: FRUIT_BBOX_OVERLAY_EN.
- Defined:
  - Stage 2 replaces o_rgb with BOX_COLOR when box_valid=1, o_de=1, and the delayed (x,y) lies on the latched rectangle border.
  - Border: (x==box_x_l or x==box_x_r) and box_y_t<=y<=box_y_b, or (y==box_y_t or y==box_y_b) and box_x_l<=x<=box_x_r.
  - x/y are delayed alongside the video.
- Undefined: o_rgb is the pure 2-cycle delay of i_rgb. Latency is 2 in both builds.

Test Plan:
- Reset, then 8x4 frames, all pixels 24'hFF0000 -> no frame_done until the 2nd fs. After it: box 0..7 x 0..3, pix_cnt=32, box_valid=0 (MIN_PIXELS=64).
- 64x64 frame, 10x10 red patch at x=20..29, y=5..14, rest 24'h000000 -> box_x_l=20, box_x_r=29, box_y_t=5, box_y_b=14, pix_cnt=100, box_valid=1, frame_done pulses 1 cycle after fs.
- Frame with only 24'h00FF00 pixels -> pix_cnt=0, box_valid=0, x_l=12'hFFF, x_r=0.
- Video latency: random RGB/sync stream, overlay off -> o_* equals inputs delayed exactly 2 cycles.
- Reset asserted mid-ACCUM with a red patch -> outputs 0; the frame after the next fs reports nothing until the following fs.
- FRUIT_BBOX_OVERLAY_EN, box 20..29/5..14 valid -> pixel (20,10) and (25,5) output 24'h00FF00; pixel (25,10) unchanged.
